// File: rtl/push_debounce_sync_if.sv
// Button-side signal bundle for push_debounce_sync: raw level in, clean level and status out.
interface push_debounce_sync_if;
    logic       push;
    logic       sypush;
    logic       busy;
    logic [7:0] glitch_cnt;

    modport master (
        output push,
        input  sypush,
        input  busy,
        input  glitch_cnt
    );

    modport slave (
        input  push,
        output sypush,
        output busy,
        output glitch_cnt
    );
endinterface

// File: rtl/push_debounce_sync.sv
// Push-button front end: synchronizer chain followed by a 4-state debounce FSM.
// Optional GLITCH_COUNT_EN macro enables the saturating rejected-bounce counter.
module push_debounce_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 50000,
    parameter int CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst,
    push_debounce_sync_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sy_q, sy_d;

    // Synchronizer stage: push is only ever observed through this chain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], bus.push};
        end
    end

    assign s = sync_p0[SYNC_STAGES-1];

    // Debounce stage: state, counter and registered output level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            sy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sy_q    <= sy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sy_d    = sy_q;
        case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    sy_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    sy_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
                sy_d    = 1'b0;
            end
        endcase
    end

    assign bus.sypush = sy_q;
    assign bus.busy   = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

`ifdef GLITCH_COUNT_EN
    logic       abort;
    logic [7:0] glitch_q;

    // An abort is a WAIT state seeing the level it is trying to leave
    assign abort = ((state_q == WAIT_HIGH) && !s) || ((state_q == WAIT_LOW) && s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_q <= 8'd0;
        end else if (abort && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign bus.glitch_cnt = glitch_q;
`else
    assign bus.glitch_cnt = 8'd0;
`endif
endmodule
